// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-to-1 streaming multiplexer.
package stream_mux_pkg;

   // Selection mode encoding
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Packet-lock state
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

endpackage : stream_mux_pkg

// File: rtl/mux_rr_pick.sv
// Rotate-priority search: first asserted request at or above ptr, wrapping to 0.
module mux_rr_pick #(
   parameter int unsigned N  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          found,
   output logic [SW-1:0] idx
);

   // Two passes: indices >= ptr first, then the wrapped range from 0
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && (SW'(j) >= ptr)) begin
            found = 1'b1;
            idx   = SW'(j);
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = SW'(j);
         end
      end
   end

endmodule : mux_rr_pick

// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream mux with packet locking and fixed / round-robin selection.
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter  int unsigned N  = 8,
   parameter  int unsigned W  = 8,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_ready,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   output logic            out_last,
   output logic [SW-1:0]   out_chan,
   input  logic            out_ready
);

   state_t          state, state_nx;
   logic [SW-1:0]   lock_chan, lock_chan_nx;
   logic [SW-1:0]   ptr, ptr_nx;

   logic            load_c;
   logic            grant_c;
   logic [SW-1:0]   cand_c;
   logic            cand_valid_c;
   logic            cand_last_c;
   logic [W-1:0]    cand_data_c;
   logic            cand_ok_c;
   logic            rr_found_c;
   logic [SW-1:0]   rr_idx_c;

   assign load_c = !out_valid || out_ready;

   mux_rr_pick #(
      .N  (N),
      .SW (SW)
   ) u_rr_pick (
      .req   (in_valid),
      .ptr   (ptr),
      .found (rr_found_c),
      .idx   (rr_idx_c)
   );

   // Candidate channel: held lock, else fixed select, else round-robin winner
   always_comb begin
      cand_c = rr_idx_c;
      if (state == ST_LOCKED) begin
         cand_c = lock_chan;
      end else if (mode == MODE_FIXED) begin
         cand_c = sel;
      end
   end

   // Extract the candidate's beat; an out-of-range index matches no channel
   always_comb begin
      cand_valid_c = 1'b0;
      cand_last_c  = 1'b0;
      cand_data_c  = '0;
      for (int k = 0; k < N; k++) begin
         if (SW'(k) == cand_c) begin
            cand_valid_c = in_valid[k];
            cand_last_c  = in_last[k];
            cand_data_c  = in_data[k*W +: W];
         end
      end
   end

   // Grant qualification; the idle round-robin path uses the picker's found flag
   always_comb begin
      cand_ok_c = cand_valid_c;
      if (state == ST_IDLE && mode == MODE_RR) begin
         cand_ok_c = rr_found_c;
      end
      grant_c = load_c && cand_ok_c && !rst;
   end

   // Next-state, lock/pointer update and one-hot in_ready
   always_comb begin
      state_nx     = state;
      lock_chan_nx = lock_chan;
      ptr_nx       = ptr;
      in_ready     = '0;
      if (grant_c) begin
         for (int k = 0; k < N; k++) begin
            in_ready[k] = (SW'(k) == cand_c);
         end
         if (cand_last_c) begin
            state_nx = ST_IDLE;
            ptr_nx   = (cand_c == SW'(N - 1)) ? '0 : cand_c + SW'(1);
         end else begin
            state_nx     = ST_LOCKED;
            lock_chan_nx = cand_c;
         end
      end
   end

   // State, lock channel and round-robin pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         lock_chan <= '0;
         ptr       <= '0;
      end else begin
         state     <= state_nx;
         lock_chan <= lock_chan_nx;
         ptr       <= ptr_nx;
      end
   end

   // Output beat register; data fields hold when no beat is loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_chan  <= '0;
      end else if (load_c) begin
         out_valid <= grant_c;
         if (grant_c) begin
            out_data <= cand_data_c;
            out_last <= cand_last_c;
            out_chan <= cand_c;
         end
      end
   end

endmodule : stream_mux_n

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: an 8-channel and a 5-channel instance.
module tb_stream_mux_n;

   typedef struct packed {
      logic [2:0] chan;
      logic       last;
      logic [7:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 8-channel instance signals
   logic [63:0] in_data8;
   logic [7:0]  in_valid8, in_last8, in_ready8;
   logic        mode8 = 1'b0;
   logic [2:0]  sel8 = 3'd0;
   logic [7:0]  out_data8;
   logic        out_valid8, out_last8;
   logic [2:0]  out_chan8;
   logic        out_ready8 = 1'b1;

   // 5-channel instance signals
   logic [39:0] in_data5;
   logic [4:0]  in_valid5, in_last5, in_ready5;
   logic        mode5 = 1'b0;
   logic [2:0]  sel5 = 3'd0;
   logic [7:0]  out_data5;
   logic        out_valid5, out_last5;
   logic [2:0]  out_chan5;
   logic        out_ready5 = 1'b1;

   // Per-channel source FIFOs {last,data}, index [dut][chan][slot]
   logic [8:0] mem [2][8][16];
   int         wr  [2][8];
   int         rd  [2][8];
   logic [7:0] rdy_s [2];

   beat_t exp0[$];
   beat_t exp1[$];
   int    checks = 0;
   int    errors = 0;

   stream_mux_n #(.N(8), .W(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_data(in_data8), .in_valid(in_valid8), .in_last(in_last8), .in_ready(in_ready8),
      .mode(mode8), .sel(sel8),
      .out_data(out_data8), .out_valid(out_valid8), .out_last(out_last8),
      .out_chan(out_chan8), .out_ready(out_ready8)
   );

   stream_mux_n #(.N(5), .W(8)) dut5 (
      .clk(clk), .rst(rst),
      .in_data(in_data5), .in_valid(in_valid5), .in_last(in_last5), .in_ready(in_ready5),
      .mode(mode5), .sel(sel5),
      .out_data(out_data5), .out_valid(out_valid5), .out_last(out_last5),
      .out_chan(out_chan5), .out_ready(out_ready5)
   );

   for (genvar k = 0; k < 8; k++) begin : g_src8
      assign in_valid8[k]       = (rd[0][k] != wr[0][k]);
      assign in_data8[k*8 +: 8] = mem[0][k][rd[0][k] % 16][7:0];
      assign in_last8[k]        = mem[0][k][rd[0][k] % 16][8];
   end

   for (genvar k = 0; k < 5; k++) begin : g_src5
      assign in_valid5[k]       = (rd[1][k] != wr[1][k]);
      assign in_data5[k*8 +: 8] = mem[1][k][rd[1][k] % 16][7:0];
      assign in_last5[k]        = mem[1][k][rd[1][k] % 16][8];
   end

   // Sample accepts away from the edge, retire them on the edge
   always @(negedge clk) begin
      rdy_s[0] = in_ready8;
      rdy_s[1] = {3'b000, in_ready5};
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 8; k++)
            if (rdy_s[d][k]) rd[d][k]++;
   end

   // Monitor for the 8-channel output stream
   always @(negedge clk) begin : mon8
      beat_t b;
      if (!rst && out_valid8 && out_ready8) begin
         checks++;
         if (exp0.size() == 0) begin
            errors++;
            $display("FAIL mon8 unexpected beat chan %0d data %0h, required none", out_chan8, out_data8);
         end else begin
            b = exp0.pop_front();
            if ({out_chan8, out_last8, out_data8} !== b) begin
               errors++;
               $display("FAIL mon8 beat actual chan %0d last %0b data %0h required chan %0d last %0b data %0h",
                        out_chan8, out_last8, out_data8, b.chan, b.last, b.data);
            end
         end
      end
   end

   // Monitor for the 5-channel output stream
   always @(negedge clk) begin : mon5
      beat_t b;
      if (!rst && out_valid5 && out_ready5) begin
         checks++;
         if (exp1.size() == 0) begin
            errors++;
            $display("FAIL mon5 unexpected beat chan %0d data %0h, required none", out_chan5, out_data5);
         end else begin
            b = exp1.pop_front();
            if ({out_chan5, out_last5, out_data5} !== b) begin
               errors++;
               $display("FAIL mon5 beat actual chan %0d last %0b data %0h required chan %0d last %0b data %0h",
                        out_chan5, out_last5, out_data5, b.chan, b.last, b.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic push(input int d, input int ch, input logic [7:0] data, input logic last);
      mem[d][ch][wr[d][ch] % 16] = {last, data};
      wr[d][ch]++;
   endtask

   task automatic expect_beat(input int d, input int ch, input logic [7:0] data, input logic last);
      beat_t b;
      b.chan = 3'(ch);
      b.last = last;
      b.data = data;
      if (d == 0) exp0.push_back(b);
      else        exp1.push_back(b);
   endtask

   task automatic flush();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 8; k++) begin
            rd[d][k] = 0;
            wr[d][k] = 0;
            for (int s = 0; s < 16; s++) mem[d][k][s] = 9'h000;
         end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush();
      cyc(1);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and fixed select
      flush();
      mode8 = 1'b0; sel8 = 3'd3; out_ready8 = 1'b1;
      push(0, 3, 8'hA5, 1'b1);
      push(0, 5, 8'h55, 1'b1);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid8), 32'h0);
      check("rst_out_data", 32'(out_data8), 32'h0);
      check("rst_out_last", 32'(out_last8), 32'h0);
      check("rst_out_chan", 32'(out_chan8), 32'h0);
      check("rst_in_ready", 32'(in_ready8), 32'h0);
      check("rst_out_valid5", 32'(out_valid5), 32'h0);
      cyc(1);
      rst = 1'b0;
      expect_beat(0, 3, 8'hA5, 1'b1);
      @(negedge clk);
      check("fixed_in_ready", 32'(in_ready8), 32'h08);
      cyc(1);
      @(negedge clk);
      check("fixed_out_chan", 32'(out_chan8), 32'h3);
      check("fixed_ready_after", 32'(in_ready8), 32'h00);
      cyc(3);
      @(negedge clk);
      check("fixed_no_ch5", 32'(out_valid8), 32'h0);
      cyc(1);

      // Round-robin fairness over channels 0, 2, 7
      do_reset();
      mode8 = 1'b1;
      for (int r = 0; r < 2; r++) begin
         push(0, 0, 8'h00, 1'b1);
         push(0, 2, 8'h02, 1'b1);
         push(0, 7, 8'h07, 1'b1);
         expect_beat(0, 0, 8'h00, 1'b1);
         expect_beat(0, 2, 8'h02, 1'b1);
         expect_beat(0, 7, 8'h07, 1'b1);
      end
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rr_valid_streak", 32'(out_valid8), 32'h1);
      end
      cyc(1);
      @(negedge clk);
      check("rr_drained", 32'(out_valid8), 32'h0);
      cyc(1);

      // Packet lock with mode/sel changes mid-packet
      do_reset();
      mode8 = 1'b1; sel8 = 3'd0;
      push(0, 1, 8'h11, 1'b0);
      push(0, 1, 8'h12, 1'b0);
      push(0, 1, 8'h13, 1'b1);
      push(0, 4, 8'h44, 1'b1);
      expect_beat(0, 1, 8'h11, 1'b0);
      expect_beat(0, 1, 8'h12, 1'b0);
      expect_beat(0, 1, 8'h13, 1'b1);
      expect_beat(0, 4, 8'h44, 1'b1);
      @(negedge clk);
      check("lock_first_ready", 32'(in_ready8), 32'h02);
      cyc(1);
      mode8 = 1'b0; sel8 = 3'd4;
      @(negedge clk);
      check("lock_hold_ready1", 32'(in_ready8), 32'h02);
      cyc(1);
      @(negedge clk);
      check("lock_hold_ready2", 32'(in_ready8), 32'h02);
      check("lock_valid_b2b", 32'(out_valid8), 32'h1);
      cyc(1);
      mode8 = 1'b1;
      @(negedge clk);
      check("lock_release_ready", 32'(in_ready8), 32'h10);
      cyc(4);

      // Reset mid-packet (ptr is non-zero beforehand)
      flush();
      push(0, 6, 8'h61, 1'b0);
      push(0, 6, 8'h62, 1'b0);
      push(0, 6, 8'h63, 1'b0);
      push(0, 6, 8'h64, 1'b1);
      expect_beat(0, 6, 8'h61, 1'b0);
      cyc(2);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid8), 32'h0);
      flush();
      push(0, 2, 8'h22, 1'b1);
      push(0, 6, 8'h66, 1'b1);
      expect_beat(0, 2, 8'h22, 1'b1);
      expect_beat(0, 6, 8'h66, 1'b1);
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready8), 32'h00);
      cyc(1);
      rst = 1'b0;
      cyc(4);

      // Backpressure: four stalled cycles then resume
      do_reset();
      mode8 = 1'b1;
      push(0, 6, 8'h61, 1'b0);
      push(0, 6, 8'h62, 1'b0);
      push(0, 6, 8'h63, 1'b1);
      expect_beat(0, 6, 8'h61, 1'b0);
      expect_beat(0, 6, 8'h62, 1'b0);
      expect_beat(0, 6, 8'h63, 1'b1);
      cyc(1);
      out_ready8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid8), 32'h1);
         check("bp_data", 32'(out_data8), 32'h61);
         check("bp_in_ready", 32'(in_ready8), 32'h00);
         cyc(1);
      end
      out_ready8 = 1'b1;
      cyc(5);

      // Odd N: round-robin wrap and out-of-range fixed select
      do_reset();
      mode5 = 1'b1;
      push(1, 3, 8'h3A, 1'b1);
      expect_beat(1, 3, 8'h3A, 1'b1);
      cyc(1);
      push(1, 0, 8'h0A, 1'b1);
      push(1, 3, 8'h3B, 1'b1);
      expect_beat(1, 0, 8'h0A, 1'b1);
      expect_beat(1, 3, 8'h3B, 1'b1);
      @(negedge clk);
      check("wrap_ptr4_ready", 32'(in_ready5), 32'h01);
      cyc(2);
      push(1, 4, 8'h4A, 1'b1);
      expect_beat(1, 4, 8'h4A, 1'b1);
      cyc(1);
      push(1, 0, 8'h0C, 1'b1);
      push(1, 3, 8'h3C, 1'b1);
      expect_beat(1, 0, 8'h0C, 1'b1);
      expect_beat(1, 3, 8'h3C, 1'b1);
      @(negedge clk);
      check("wrap_after_ch4_ready", 32'(in_ready5), 32'h01);
      cyc(3);
      mode5 = 1'b0; sel5 = 3'd6;
      for (int k = 0; k < 5; k++) push(1, k, 8'(8'hB0 + k), 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("sel6_in_ready", 32'(in_ready5), 32'h00);
         check("sel6_out_valid", 32'(out_valid5), 32'h0);
         cyc(1);
      end
      sel5 = 3'd4;
      expect_beat(1, 4, 8'hB4, 1'b1);
      @(negedge clk);
      check("sel4_in_ready", 32'(in_ready5), 32'h10);
      cyc(3);

      check("exp8_empty", 32'(exp0.size()), 32'h0);
      check("exp5_empty", 32'(exp1.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_stream_mux_n
